seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 87 ++++++++
 rtl/seq_alu_muldiv.sv | 144 ++++++++++++++
 rtl/seq_alu.sv | 185 ++++++++++++++++++
 tb/tb_seq_alu.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu shared definitions: opcodes, funct encodings, states.
// Imported by seq_alu and seq_alu_muldiv.
package seq_alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  typedef enum logic [3:0] {
    OP_NONE,
    OP_ADD,
    OP_SUB,
    OP_SLL,
    OP_SLT,
    OP_SLTU,
    OP_XOR,
    OP_SRL,
    OP_SRA,
    OP_OR,
    OP_AND,
    OP_PASSB,
    OP_JUMP,
    OP_CMP,
    OP_MULDIV
  } alu_op_e;

  function automatic alu_op_e f3_op(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_e o;
    case (f3)
      F3_ADD:  o = alt ? OP_SUB : OP_ADD;
      F3_SLL:  o = OP_SLL;
      F3_SLT:  o = OP_SLT;
      F3_SLTU: o = OP_SLTU;
      F3_XOR:  o = OP_XOR;
      F3_SR:   o = alt ? OP_SRA : OP_SRL;
      F3_OR:   o = OP_OR;
      F3_AND:  o = OP_AND;
      default: o = OP_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative multiply/divide, one bit per cycle.
// Signs are stripped at start and restored on the final step.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [2:0]      op,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  logic            busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] sh_q, sh_d;
  logic            neg_q, neg_d;
  logic            zero_q, zero_d;

  logic            sa, sb, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   mul_sum, div_t, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] acc_n, sh_n;
  logic [2*XLEN-1:0] prod, prod_s;

  // operand signedness and magnitudes at start
  always_comb begin
    sa = (op == F3_MULH) || (op == F3_MULHSU) ||
         (op == F3_DIV) || (op == F3_REM);
    sb = (op == F3_MULH) || (op == F3_DIV) ||
         (op == F3_REM);
    a_neg = sa && src_a[XLEN-1];
    b_neg = sb && src_b[XLEN-1];
    mag_a = a_neg ? -src_a : src_a;
    mag_b = b_neg ? -src_b : src_b;
  end

  // one shift-add or restoring-subtract step
  always_comb begin
    mul_sum  = {1'b0, acc_q} +
               (sh_q[0] ? {1'b0, opnd_q} : '0);
    div_t    = {acc_q, sh_q[XLEN-1]};
    div_diff = div_t - {1'b0, opnd_q};
    div_ge   = div_t >= {1'b0, opnd_q};
    if (op_q[2]) begin
      acc_n = div_ge ? div_diff[XLEN-1:0]
                     : div_t[XLEN-1:0];
      sh_n  = {sh_q[XLEN-2:0], div_ge};
    end else begin
      acc_n = mul_sum[XLEN:1];
      sh_n  = {mul_sum[0], sh_q[XLEN-1:1]};
    end
  end

  // sign restore and result select from the final step
  always_comb begin
    prod   = {acc_n, sh_n};
    prod_s = neg_q ? -prod : prod;
    case (op_q)
      F3_MUL:
        result = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:
        result = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:
        result = zero_q ? '1
               : (neg_q ? -sh_n : sh_n);
      default:
        result = neg_q ? -acc_n : acc_n;
    endcase
  end

  assign done = busy_q && (cnt_q == CNT_LAST);

  // load on start, then iterate until the last bit
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    opnd_d = opnd_q;
    acc_d  = acc_q;
    sh_d   = sh_q;
    neg_d  = neg_q;
    zero_d = zero_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      op_d   = op;
      acc_d  = '0;
      zero_d = (src_b == '0);
      neg_d  = (op[2] && op[1]) ? a_neg
                                : (a_neg ^ b_neg);
      if (op[2]) begin
        opnd_d = mag_b;
        sh_d   = mag_a;
      end else begin
        opnd_d = mag_a;
        sh_d   = mag_b;
      end
    end else if (busy_q) begin
      acc_d = acc_n;
      sh_d  = sh_n;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  // datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= '0;
      opnd_q <= '0;
      acc_q  <= '0;
      sh_q   <= '0;
      neg_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      opnd_q <= opnd_d;
      acc_q  <= acc_d;
      sh_q   <= sh_d;
      neg_q  <= neg_d;
      zero_q <= zero_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked RV ALU, single-cycle base ops.
// Define SEQ_ALU_MULDIV_EN for iterative M-extension ops.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            branch_q, branch_d;
  logic            alive_q, alive_d;

  alu_op_e         op;
  logic            accept;
  logic [XLEN-1:0] alu_res;
  logic            alu_br;
  logic            eq, lt, ltu, taken;
  logic [SHAMT_W-1:0] shamt;

  assign in_ready = alive_q &&
    ((state_q == ST_IDLE) ||
     ((state_q == ST_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign branch    = branch_q;

`ifdef SEQ_ALU_MULDIV_EN
  logic            md_start, md_done;
  logic [XLEN-1:0] md_result;

  assign md_start = accept && (op == OP_MULDIV);

  seq_alu_muldiv #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .src_a  (src_a),
    .src_b  (src_b),
    .op     (funct3),
    .done   (md_done),
    .result (md_result)
  );
`endif

  // decode opcode/funct fields into an internal op
  always_comb begin
    op = OP_NONE;
    unique case (1'b1)
      (opcode == OPC_OP): begin
        if (funct7 == F7_BASE) begin
          op = f3_op(funct3, 1'b0);
        end else if ((funct7 == F7_ALT) &&
                     ((funct3 == F3_ADD) ||
                      (funct3 == F3_SR))) begin
          op = f3_op(funct3, 1'b1);
        end else if (funct7 == F7_MULDIV) begin
`ifdef SEQ_ALU_MULDIV_EN
          op = OP_MULDIV;
`else
          op = OP_NONE;
`endif
        end
      end
      (opcode == OPC_OP_IMM):
        op = f3_op(funct3,
                   funct7[5] && (funct3 == F3_SR));
      (opcode == OPC_LOAD),
      (opcode == OPC_STORE),
      (opcode == OPC_AUIPC):
        op = OP_ADD;
      (opcode == OPC_JAL),
      (opcode == OPC_JALR):
        op = OP_JUMP;
      (opcode == OPC_LUI):
        op = OP_PASSB;
      (opcode == OPC_BRANCH):
        op = OP_CMP;
      default:
        op = OP_NONE;
    endcase
  end

  // single-cycle datapath and branch compare
  always_comb begin
    shamt = src_b[SHAMT_W-1:0];
    eq    = (src_a == src_b);
    lt    = ($signed(src_a) < $signed(src_b));
    ltu   = (src_a < src_b);
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = !lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = !ltu;
      default: taken = 1'b0;
    endcase
    case (op)
      OP_ADD, OP_JUMP: alu_res = src_a + src_b;
      OP_SUB, OP_CMP:  alu_res = src_a - src_b;
      OP_SLL:   alu_res = src_a << shamt;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, lt};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, ltu};
      OP_XOR:   alu_res = src_a ^ src_b;
      OP_SRL:   alu_res = src_a >> shamt;
      OP_SRA:   alu_res = $signed(src_a) >>> shamt;
      OP_OR:    alu_res = src_a | src_b;
      OP_AND:   alu_res = src_a & src_b;
      OP_PASSB: alu_res = src_b;
      default:  alu_res = '0;
    endcase
    alu_br = (op == OP_CMP) ? taken
                            : (op == OP_JUMP);
  end

  // handshake FSM next state and result capture
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    branch_d = branch_q;
    alive_d  = 1'b1;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if ((state_q == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
        end
        if (accept) begin
          state_d  = ST_DONE;
          result_d = alu_res;
          branch_d = alu_br;
`ifdef SEQ_ALU_MULDIV_EN
          if (op == OP_MULDIV) begin
            state_d = ST_BUSY;
          end
`endif
        end
      end
`ifdef SEQ_ALU_MULDIV_EN
      ST_BUSY: begin
        if (md_done) begin
          state_d  = ST_DONE;
          result_d = md_result;
          branch_d = 1'b0;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      branch_q <= 1'b0;
      alive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      branch_q <= branch_d;
      alive_q  <= alive_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu.
// M-op expectations follow SEQ_ALU_MULDIV_EN.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int XLEN = 32;
`ifdef SEQ_ALU_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  localparam int MD_LAT = MD_EN ? XLEN + 1 : 1;

  typedef struct packed {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
    logic        chk_res;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        branch;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(
    .XLEN (XLEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .branch    (branch)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    opcode   = v.opc;
    funct3   = v.f3;
    funct7   = v.f7;
    src_a    = v.a;
    src_b    = v.b;
    in_valid = 1'b1;
  endtask

  task automatic send(input vec_t v);
    drive(v);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_ready got %b want 0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (result !== 32'h0) begin
      errors++;
      $display("FAIL rst_result got %h want 0", result);
    end
    checks++;
    if (branch !== 1'b0) begin
      errors++;
      $display("FAIL rst_branch got %b want 0", branch);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rel_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic run_table(input string nm, input vec_t v[]);
    foreach (v[i]) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s[%0d] in_ready got %b want 1",
                 nm, i, in_ready);
      end
      send(v[i]);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s[%0d] out_valid got %b want 1",
                 nm, i, out_valid);
      end
      if (v[i].chk_res) begin
        checks++;
        if (result !== v[i].res) begin
          errors++;
          $display("FAIL %s[%0d] result got %h want %h",
                   nm, i, result, v[i].res);
        end
      end
      checks++;
      if (branch !== v[i].br) begin
        errors++;
        $display("FAIL %s[%0d] branch got %b want %b",
                 nm, i, branch, v[i].br);
      end
      tick();
    end
  endtask

  task automatic test_alu;
    vec_t v[];
    v = new[21];
    v[0]  = '{OPC_OP, 3'b000, 7'h00, 32'h7FFFFFFF,
              32'h1, 32'h80000000, 1'b0, 1'b1};
    v[1]  = '{OPC_OP, 3'b000, 7'h20, 32'h5,
              32'h7, 32'hFFFFFFFE, 1'b0, 1'b1};
    v[2]  = '{OPC_OP_IMM, 3'b000, 7'h20, 32'h5,
              32'h7, 32'hC, 1'b0, 1'b1};
    v[3]  = '{OPC_OP, 3'b001, 7'h00, 32'h1,
              32'h21, 32'h2, 1'b0, 1'b1};
    v[4]  = '{OPC_OP, 3'b010, 7'h00, 32'hFFFFFFFF,
              32'h1, 32'h1, 1'b0, 1'b1};
    v[5]  = '{OPC_OP, 3'b011, 7'h00, 32'hFFFFFFFF,
              32'h1, 32'h0, 1'b0, 1'b1};
    v[6]  = '{OPC_OP, 3'b100, 7'h00, 32'hF0F0F0F0,
              32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b1};
    v[7]  = '{OPC_OP, 3'b101, 7'h00, 32'h80000000,
              32'h4, 32'h08000000, 1'b0, 1'b1};
    v[8]  = '{OPC_OP, 3'b101, 7'h20, 32'h80000000,
              32'h24, 32'hF8000000, 1'b0, 1'b1};
    v[9]  = '{OPC_OP, 3'b110, 7'h00, 32'hF0F0F0F0,
              32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b1};
    v[10] = '{OPC_OP, 3'b111, 7'h00, 32'hF0F0F0F0,
              32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b1};
    v[11] = '{OPC_OP_IMM, 3'b101, 7'h20, 32'h80000001,
              32'h1, 32'hC0000000, 1'b0, 1'b1};
    v[12] = '{OPC_LUI, 3'b000, 7'h00, 32'hDEADBEEF,
              32'h12345000, 32'h12345000, 1'b0, 1'b1};
    v[13] = '{OPC_JAL, 3'b000, 7'h00, 32'h1000,
              32'h8, 32'h1008, 1'b1, 1'b1};
    v[14] = '{OPC_AUIPC, 3'b000, 7'h00, 32'h1000,
              32'hFFFFF000, 32'h0, 1'b0, 1'b1};
    v[15] = '{OPC_LOAD, 3'b010, 7'h00, 32'h100,
              32'hFFFFFFFC, 32'hFC, 1'b0, 1'b1};
    v[16] = '{OPC_STORE, 3'b010, 7'h00, 32'h200,
              32'h10, 32'h210, 1'b0, 1'b1};
    v[17] = '{OPC_OP, 3'b000, 7'h02, 32'h5,
              32'h7, 32'h0, 1'b0, 1'b1};
    v[18] = '{7'h7F, 3'b000, 7'h00, 32'h5,
              32'h7, 32'h0, 1'b0, 1'b1};
    v[19] = '{OPC_OP, 3'b001, 7'h20, 32'h1,
              32'h1, 32'h0, 1'b0, 1'b1};
    v[20] = '{OPC_OP_IMM, 3'b010, 7'h00, 32'hFFFFFFFE,
              32'hFFFFFFFF, 32'h1, 1'b0, 1'b1};
    run_table("alu", v);
  endtask

  task automatic test_branch;
    vec_t v[];
    v = new[9];
    v[0] = '{OPC_BRANCH, F3_BEQ, 7'h00, 32'h5,
             32'h5, 32'h0, 1'b1, 1'b1};
    v[1] = '{OPC_BRANCH, F3_BNE, 7'h00, 32'h5,
             32'h5, 32'h0, 1'b0, 1'b1};
    v[2] = '{OPC_BRANCH, F3_BLT, 7'h00, 32'hFFFFFFFF,
             32'h1, 32'hFFFFFFFE, 1'b1, 1'b1};
    v[3] = '{OPC_BRANCH, F3_BLTU, 7'h00, 32'hFFFFFFFF,
             32'h1, 32'hFFFFFFFE, 1'b0, 1'b1};
    v[4] = '{OPC_BRANCH, F3_BGE, 7'h00, 32'hFFFFFFFF,
             32'h1, 32'hFFFFFFFE, 1'b0, 1'b1};
    v[5] = '{OPC_BRANCH, F3_BGEU, 7'h00, 32'hFFFFFFFF,
             32'h1, 32'hFFFFFFFE, 1'b1, 1'b1};
    v[6] = '{OPC_BRANCH, 3'b010, 7'h00, 32'h3,
             32'h4, 32'h0, 1'b0, 1'b0};
    v[7] = '{OPC_BRANCH, 3'b011, 7'h00, 32'h3,
             32'h4, 32'h0, 1'b0, 1'b0};
    v[8] = '{OPC_JALR, 3'b000, 7'h00, 32'h100,
             32'hFFFFFFFE, 32'hFE, 1'b1, 1'b1};
    run_table("br", v);
  endtask

  task automatic test_muldiv;
    vec_t v[15];
    int lat;
    int bad;
    logic [31:0] exp;
    v[0]  = '{OPC_OP, F3_DIV, F7_MULDIV, 32'h80000000,
              32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1};
    v[1]  = '{OPC_OP, F3_REM, F7_MULDIV, 32'h80000000,
              32'hFFFFFFFF, 32'h0, 1'b0, 1'b1};
    v[2]  = '{OPC_OP, F3_DIVU, F7_MULDIV, 32'h12345678,
              32'h0, 32'hFFFFFFFF, 1'b0, 1'b1};
    v[3]  = '{OPC_OP, F3_MULH, F7_MULDIV, 32'hFFFFFFFF,
              32'hFFFFFFFF, 32'h0, 1'b0, 1'b1};
    v[4]  = '{OPC_OP, F3_MULHU, F7_MULDIV, 32'hFFFFFFFF,
              32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1};
    v[5]  = '{OPC_OP, F3_MUL, F7_MULDIV, 32'h7,
              32'h6, 32'h2A, 1'b0, 1'b1};
    v[6]  = '{OPC_OP, F3_DIV, F7_MULDIV, 32'hFFFFFFF9,
              32'h2, 32'hFFFFFFFD, 1'b0, 1'b1};
    v[7]  = '{OPC_OP, F3_REM, F7_MULDIV, 32'hFFFFFFF9,
              32'h2, 32'hFFFFFFFF, 1'b0, 1'b1};
    v[8]  = '{OPC_OP, F3_DIV, F7_MULDIV, 32'hFFFFFFF9,
              32'h0, 32'hFFFFFFFF, 1'b0, 1'b1};
    v[9]  = '{OPC_OP, F3_REM, F7_MULDIV, 32'hFFFFFFF9,
              32'h0, 32'hFFFFFFF9, 1'b0, 1'b1};
    v[10] = '{OPC_OP, F3_MULHSU, F7_MULDIV, 32'hFFFFFFFF,
              32'h2, 32'hFFFFFFFF, 1'b0, 1'b1};
    v[11] = '{OPC_OP, F3_REMU, F7_MULDIV, 32'h7,
              32'h3, 32'h1, 1'b0, 1'b1};
    v[12] = '{OPC_OP, F3_MUL, F7_MULDIV, 32'hFFFFFFFF,
              32'hFFFFFFFF, 32'h1, 1'b0, 1'b1};
    v[13] = '{OPC_OP, F3_MULH, F7_MULDIV, 32'h80000000,
              32'h80000000, 32'h40000000, 1'b0, 1'b1};
    v[14] = '{OPC_OP, F3_REMU, F7_MULDIV, 32'h55,
              32'h0, 32'h55, 1'b0, 1'b1};
    foreach (v[i]) begin
      exp = MD_EN ? v[i].res : 32'h0;
      send(v[i]);
      lat = 1;
      bad = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
        if (in_ready !== 1'b0) bad++;
        tick();
        lat++;
      end
      checks++;
      if (lat != MD_LAT) begin
        errors++;
        $display("FAIL md[%0d] latency got %0d want %0d",
                 i, lat, MD_LAT);
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL md[%0d] busy_in_ready got %0d want 0",
                 i, bad);
      end
      checks++;
      if (result !== exp) begin
        errors++;
        $display("FAIL md[%0d] result got %h want %h",
                 i, result, exp);
      end
      checks++;
      if (branch !== 1'b0) begin
        errors++;
        $display("FAIL md[%0d] branch got %b want 0",
                 i, branch);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    vec_t sra_v;
    vec_t add_v;
    sra_v = '{OPC_OP, F3_SR, F7_ALT, 32'h80000000,
              32'h4, 32'hF8000000, 1'b0, 1'b1};
    add_v = '{OPC_OP, F3_ADD, F7_BASE, 32'h2,
              32'h3, 32'h5, 1'b0, 1'b1};
    out_ready = 1'b0;
    send(sra_v);
    drive(add_v);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== 32'hF8000000
          || branch !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] v/res/br got %b/%h/%b want 1/f8000000/0",
                 i, out_valid, result, branch);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_in_ready[%0d] got %b want 0",
                 i, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_in_ready got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h5) begin
      errors++;
      $display("FAIL b2b_result got %b/%h want 1/00000005",
               out_valid, result);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_op;
    vec_t div_v;
    vec_t add_v;
    int stale;
    div_v = '{OPC_OP, F3_DIV, F7_MULDIV, 32'h8,
              32'h2, 32'h4, 1'b0, 1'b1};
    add_v = '{OPC_OP, F3_ADD, F7_BASE, 32'h1,
              32'h1, 32'h2, 1'b0, 1'b1};
    send(div_v);
    repeat (9) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (result !== 32'h0 || branch !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_res got %h/%b want 0/0",
               result, branch);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_rst[%0d] rdy/vld got %b/%b want 0/0",
                 i, in_ready, out_valid);
      end
      tick();
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_rel_in_ready got %b want 1", in_ready);
    end
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) stale++;
      tick();
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL mid_stale_valid got %0d want 0", stale);
    end
    send(add_v);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h2) begin
      errors++;
      $display("FAIL post_rst_add got %b/%h want 1/00000002",
               out_valid, result);
    end
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opcode    = '0;
    funct3    = '0;
    funct7    = '0;
    src_a     = '0;
    src_b     = '0;
    test_reset();
    test_alu();
    test_branch();
    test_muldiv();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
